// File: rtl/csla_arbiter.sv
// Round-robin arbiter feeding one shared carry-select adder through a two-stage pipeline.
// Optional per-requester grant counters are enabled by defining CSLA_ARB_GNT_CNT_EN.
module csla_arbiter #(
  parameter int unsigned WIDTH = 29,
  parameter int unsigned NREQ  = 4,
  parameter int unsigned IDW   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         i_req_valid,
  input  logic [NREQ*WIDTH-1:0]   i_X_0,
  input  logic [NREQ*WIDTH-1:0]   i_X_1,
  output logic [NREQ-1:0]         o_req_ready,
  output logic                    o_valid,
  output logic [WIDTH:0]          o_S,
  output logic [IDW-1:0]          o_id,
  input  logic                    i_ready,
`ifdef CSLA_ARB_GNT_CNT_EN
  output logic [NREQ*16-1:0]      o_gnt_cnt,
`endif
  output logic                    o_busy
);

  localparam int unsigned LOW  = (WIDTH < 5) ? WIDTH : 5;
  localparam int unsigned NBLK = (WIDTH - LOW + 5) / 6;
  localparam int unsigned PW   = LOW + 6 * NBLK;

  logic             r_a_valid;
  logic [WIDTH-1:0] r_a_x0;
  logic [WIDTH-1:0] r_a_x1;
  logic [IDW-1:0]   r_a_id;
  logic             r_b_valid;
  logic [WIDTH:0]   r_b_s;
  logic [IDW-1:0]   r_b_id;
  logic [IDW-1:0]   r_ptr;

  logic             w_out_xfer;
  logic             w_b_load;
  logic             w_a_accept;
  logic             w_found;
  logic             w_req_xfer;
  logic [IDW-1:0]   w_gnt_id;
  logic [IDW-1:0]   w_idx;
  logic [IDW:0]     w_pos;
  logic [NREQ-1:0]  w_gnt_oh;
  logic [WIDTH-1:0] w_sel_x0;
  logic [WIDTH-1:0] w_sel_x1;
  logic [WIDTH:0]   w_sum;

  logic [PW-1:0]    w_pa;
  logic [PW-1:0]    w_pb;
  logic [PW-1:0]    w_ps;
  logic             w_c;
  logic [6:0]       w_blk0;
  logic [6:0]       w_blk1;
  logic [PW:0]      w_full;

  assign w_out_xfer = r_b_valid & i_ready;
  assign w_b_load   = r_a_valid & (~r_b_valid | w_out_xfer);
  assign w_a_accept = ~r_a_valid | w_b_load;

  // Search p, p+1, ... wrapping at NREQ; first valid requester wins.
  always_comb begin
    w_found  = 1'b0;
    w_gnt_id = '0;
    w_pos    = '0;
    w_idx    = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_pos = {1'b0, r_ptr} + (IDW+1)'(i);
      if (w_pos >= (IDW+1)'(NREQ)) w_pos = w_pos - (IDW+1)'(NREQ);
      w_idx = w_pos[IDW-1:0];
      if (!w_found && i_req_valid[w_idx]) begin
        w_found  = 1'b1;
        w_gnt_id = w_idx;
      end
    end
  end

  always_comb begin
    w_gnt_oh = '0;
    if (w_found) w_gnt_oh[w_gnt_id] = 1'b1;
  end

  // Ready is forced low while reset is held, independent of the clock.
  assign o_req_ready = (rst && w_a_accept) ? w_gnt_oh : '0;
  assign w_req_xfer  = w_found & w_a_accept;
  assign w_sel_x0    = i_X_0[w_gnt_id*WIDTH +: WIDTH];
  assign w_sel_x1    = i_X_1[w_gnt_id*WIDTH +: WIDTH];

  // Carry-select adder: 5-bit ripple base, then 6-bit units each precomputing
  // both carry-in cases. Operands are zero-padded to whole units, so the bit
  // just above WIDTH in the padded sum is the true carry-out.
  always_comb begin
    w_pa   = PW'(r_a_x0);
    w_pb   = PW'(r_a_x1);
    w_ps   = '0;
    w_c    = 1'b0;
    w_blk0 = '0;
    w_blk1 = '0;
    {w_c, w_ps[LOW-1:0]} = {1'b0, w_pa[LOW-1:0]} + {1'b0, w_pb[LOW-1:0]};
    for (int unsigned j = 0; j < NBLK; j++) begin
      w_blk0 = {1'b0, w_pa[LOW+6*j +: 6]} + {1'b0, w_pb[LOW+6*j +: 6]};
      w_blk1 = {1'b0, w_pa[LOW+6*j +: 6]} + {1'b0, w_pb[LOW+6*j +: 6]} + 7'd1;
      w_ps[LOW+6*j +: 6] = w_c ? w_blk1[5:0] : w_blk0[5:0];
      w_c = w_c ? w_blk1[6] : w_blk0[6];
    end
  end

  assign w_full = {w_c, w_ps};
  assign w_sum  = w_full[WIDTH:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a_valid <= 1'b0;
      r_a_x0    <= '0;
      r_a_x1    <= '0;
      r_a_id    <= '0;
      r_b_valid <= 1'b0;
      r_b_s     <= '0;
      r_b_id    <= '0;
      r_ptr     <= '0;
    end else begin
      if (w_req_xfer) begin
        r_a_valid <= 1'b1;
        r_a_x0    <= w_sel_x0;
        r_a_x1    <= w_sel_x1;
        r_a_id    <= w_gnt_id;
        r_ptr     <= (w_gnt_id == IDW'(NREQ - 1)) ? '0 : w_gnt_id + 1'b1;
      end else if (w_b_load) begin
        r_a_valid <= 1'b0;
      end
      if (w_b_load) begin
        r_b_valid <= 1'b1;
        r_b_s     <= w_sum;
        r_b_id    <= r_a_id;
      end else if (w_out_xfer) begin
        r_b_valid <= 1'b0;
      end
    end
  end

  assign o_valid = r_b_valid;
  assign o_S     = r_b_s;
  assign o_id    = r_b_id;
  assign o_busy  = r_a_valid | r_b_valid;

`ifdef CSLA_ARB_GNT_CNT_EN
  logic [15:0] r_gnt_cnt [NREQ];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned k = 0; k < NREQ; k++) r_gnt_cnt[k] <= '0;
    end else if (w_req_xfer) begin
      r_gnt_cnt[w_gnt_id] <= r_gnt_cnt[w_gnt_id] + 16'd1;
    end
  end

  always_comb begin
    o_gnt_cnt = '0;
    for (int unsigned k = 0; k < NREQ; k++) o_gnt_cnt[k*16 +: 16] = r_gnt_cnt[k];
  end
`endif

endmodule

// File: tb/tb_csla_arbiter.sv
// Randomized bench for csla_arbiter: a queue-based model of accepted sums plus
// directed literal scenarios (single request, contention, backpressure, skip, reset).
module tb_csla_arbiter;
  localparam int W   = 29;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [N*W-1:0]   x0;
  logic [N*W-1:0]   x1;
  logic [N-1:0]     req_ready;
  logic             o_valid;
  logic [W:0]       o_S;
  logic [IDW-1:0]   o_id;
  logic             i_ready;
  logic             o_busy;
`ifdef CSLA_ARB_GNT_CNT_EN
  logic [N*16-1:0]  gnt_cnt;
`endif

  csla_arbiter #(.WIDTH(W), .NREQ(N), .IDW(IDW)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_req_valid (req_valid),
    .i_X_0       (x0),
    .i_X_1       (x1),
    .o_req_ready (req_ready),
    .o_valid     (o_valid),
    .o_S         (o_S),
    .o_id        (o_id),
    .i_ready     (i_ready),
`ifdef CSLA_ARB_GNT_CNT_EN
    .o_gnt_cnt   (gnt_cnt),
`endif
    .o_busy      (o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W:0] sum;
    int         id;
  } item_t;

  // Model: accepted results in order; head is visible once it has aged one edge.
  item_t mq[$];
  bit    m_vis;
  int    m_ptr;
  int    m_cnt[N];
  int    n_chk;
  int    n_pass;

  logic [N-1:0] cap_ready;
  logic         cap_valid;
  logic [W:0]   cap_S;
  logic [IDW-1:0] cap_id;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    mq.delete();
    m_vis = 1'b0;
    m_ptr = 0;
    for (int k = 0; k < N; k++) m_cnt[k] = 0;
  endtask

  // One clock: compare at negedge, advance model at posedge, return at posedge+1.
  task automatic step();
    logic [N-1:0] e_ready;
    int           gnt;
    bit           stall;
    logic [W:0]   s;
    @(negedge clk);
    stall = (mq.size() == 2) && !i_ready;
    gnt = -1;
    for (int i = 0; i < N; i++) begin
      int k;
      k = (m_ptr + i) % N;
      if (gnt < 0 && req_valid[k]) gnt = k;
    end
    e_ready = '0;
    if (!stall && gnt >= 0) e_ready[gnt] = 1'b1;
    chk("ready", req_ready, e_ready);
    chk("valid", o_valid, m_vis);
    chk("busy", o_busy, mq.size() > 0);
    if (m_vis) begin
      chk("sum", o_S, mq[0].sum);
      chk("id", o_id, mq[0].id);
    end
`ifdef CSLA_ARB_GNT_CNT_EN
    for (int k = 0; k < N; k++) chk("gnt_cnt", gnt_cnt[k*16 +: 16], m_cnt[k] % 65536);
`endif
    cap_ready = req_ready;
    cap_valid = o_valid;
    cap_S     = o_S;
    cap_id    = o_id;
    @(posedge clk);
    if (m_vis && i_ready) void'(mq.pop_front());
    m_vis = mq.size() > 0;
    if (e_ready != '0) begin
      s = (W+1)'(x0[gnt*W +: W]) + (W+1)'(x1[gnt*W +: W]);
      mq.push_back('{sum: s, id: gnt});
      m_ptr = (gnt + 1) % N;
      m_cnt[gnt]++;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_ready", req_ready, '0);
    chk("rst_S", o_S, '0);
    chk("rst_id", o_id, '0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic rand_ops();
    for (int k = 0; k < N; k++) begin
      x0[k*W +: W] = ($urandom % 8 == 0) ? '1 : W'($urandom);
      x1[k*W +: W] = ($urandom % 8 == 0) ? '1 : W'($urandom);
    end
  endtask

  initial begin
    int acc;
    logic [W:0] held;
    n_chk = 0;
    n_pass = 0;
    rst = 1'b0;
    req_valid = '0;
    x0 = '0;
    x1 = '0;
    i_ready = 1'b1;
    model_reset();
    #2 req_valid = '1;
    #1;
    chk("reset_ready", req_ready, '0);
    chk("reset_valid", o_valid, 1'b0);
    chk("reset_S", o_S, '0);
    chk("reset_id", o_id, '0);
    chk("reset_busy", o_busy, 1'b0);
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Single request from requester 2 on the first edge after release.
    x0[2*W +: W] = 29'h1FFFFFFF;
    x1[2*W +: W] = 29'h00000001;
    req_valid = 4'b0100;
    step();
    chk("single_grant", cap_ready, 4'b0100);
    req_valid = '0;
    step();
    chk("single_not_yet", cap_valid, 1'b0);
    step();
    chk("single_valid", cap_valid, 1'b1);
    chk("single_sum", cap_S, 30'h20000000);
    chk("single_id", cap_id, 2);
    repeat (2) step();

    // Full contention from a fresh pointer.
    do_reset();
    rand_ops();
    req_valid = '1;
    for (int i = 0; i < 8; i++) begin
      logic [N-1:0] e;
      step();
      e = '0;
      e[i % N] = 1'b1;
      chk("rr_order", cap_ready, e);
      if (i >= 2) begin
        chk("rr_valid", cap_valid, 1'b1);
        chk("rr_id", cap_id, (i - 2) % N);
      end
    end

    // Backpressure from an empty pipeline.
    req_valid = '0;
    repeat (3) step();
    i_ready = 1'b0;
    req_valid = '1;
    acc = 0;
    held = '0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (cap_ready != '0) acc++;
      if (i >= 2) chk("bp_ready_low", cap_ready, '0);
      if (i >= 3) chk("bp_S_stable", cap_S, held);
      held = cap_S;
    end
    chk("bp_accepted", acc, 2);
    i_ready = 1'b1;
    req_valid = '0;
    step();
    chk("bp_drain0", cap_id, 0);
    step();
    chk("bp_drain1", cap_id, 1);
    repeat (2) step();

    // Pointer skip: p=1 with only requester 0 valid.
    do_reset();
    req_valid = 4'b0001;
    step();
    chk("skip_first", cap_ready, 4'b0001);
    step();
    chk("skip_wrap", cap_ready, 4'b0001);
    req_valid = '1;
    step();
    chk("skip_ptr1", cap_ready, 4'b0010);
    req_valid = '0;
    repeat (3) step();

    // Reset while both stages hold data.
    i_ready = 1'b0;
    req_valid = '1;
    step();
    step();
    chk("pre_rst_busy", o_busy, 1'b1);
    chk("pre_rst_valid", o_valid, 1'b1);
    do_reset();
    req_valid = '0;
    i_ready = 1'b1;
    repeat (3) step();
    req_valid = '1;
    step();
    chk("post_rst_ptr", cap_ready, 4'b0001);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom % 500 == 0) do_reset();
      req_valid = N'($urandom);
      i_ready = ($urandom % 4) != 0;
      rand_ops();
      step();
    end

`ifdef CSLA_ARB_GNT_CNT_EN
    do_reset();
    req_valid = 4'b0010;
    i_ready = 1'b1;
    repeat (65537) step();
    chk("cnt_slice0", gnt_cnt[15:0], 16'd0);
    chk("cnt_slice1", gnt_cnt[31:16], 16'd1);
    chk("cnt_slice2", gnt_cnt[47:32], 16'd0);
    chk("cnt_slice3", gnt_cnt[63:48], 16'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
